// File: rtl/imem_pkg.sv
// Shared sizing defaults and FSM encoding for the instruction-memory load arbiter.
package imem_pkg;

  localparam int WORD_SIZE_DEF  = 32;
  localparam int DEPTH_DEF      = 256;
  localparam int ADDR_W_DEF     = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles loader bytes big-endian into words; word_done pulses the cycle after
// the last byte of a word is accepted, while word still holds the complete word.
module byte_word_packer
  import imem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [7:0]           byte_data,
  output logic [1:0]           byte_cnt,
  output logic [WORD_SIZE-1:0] word,
  output logic                 word_done
);

  logic [1:0]           cnt_reg;
  logic [WORD_SIZE-1:0] asm_reg;
  logic                 done_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_reg  <= 2'd0;
      asm_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= byte_en && (cnt_reg == 2'(BYTES_PER_WORD - 1));
      if (byte_en) begin
        // Shifting left puts the first byte of a word in the top lane.
        cnt_reg <= cnt_reg + 2'd1;
        asm_reg <= {asm_reg[WORD_SIZE-9:0], byte_data};
      end
    end
  end

  assign byte_cnt  = cnt_reg;
  assign word      = asm_reg;
  assign word_done = done_reg;

endmodule

// File: rtl/imem_load_arbiter.sv
// Arbitrates instruction memory between a byte-serial program loader and CPU
// fetch: loads words while stalling the CPU, then hands the read port to the CPU.
module imem_load_arbiter
  import imem_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_done,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] instruction,
  output logic                 cpu_stall,
  output logic                 pc_misaligned,
  output logic [ADDR_W-1:0]    mem_raddr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_waddr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [ADDR_W:0]      words_loaded,
  output logic                 load_err
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t               state_reg;
  logic [ADDR_W:0]      word_cnt_reg;
  logic                 err_reg;
  logic                 mem_we_reg;
  logic [ADDR_W-1:0]    mem_waddr_reg;
  logic [WORD_SIZE-1:0] mem_wdata_reg;

  logic                 byte_en;
  logic [1:0]           byte_cnt;
  logic [WORD_SIZE-1:0] word;
  logic                 word_done;
  logic                 unused_pc_hi;

  assign byte_ready = (state_reg == LOAD) && !load_done;
  assign byte_en    = byte_valid && byte_ready;

  byte_word_packer #(
    .WORD_SIZE (WORD_SIZE)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start || load_done),
    .byte_en   (byte_en),
    .byte_data (byte_data),
    .byte_cnt  (byte_cnt),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      err_reg       <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_we_reg <= 1'b0;
      unique case (state_reg)
        IDLE, RUN: begin
          if (load_start) begin
            state_reg    <= LOAD;
            word_cnt_reg <= '0;
            err_reg      <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            // Restart drops any word still in flight along with the counters.
            word_cnt_reg <= '0;
            err_reg      <= 1'b0;
          end else begin
            if (word_done) begin
              if (word_cnt_reg == FULL_COUNT) begin
                err_reg <= 1'b1;
              end else begin
                mem_we_reg    <= 1'b1;
                mem_waddr_reg <= word_cnt_reg[ADDR_W-1:0];
                mem_wdata_reg <= word;
                word_cnt_reg  <= word_cnt_reg + (ADDR_W + 1)'(1);
              end
            end
            if (load_done) begin
              state_reg <= RUN;
              if (byte_cnt != 2'd0) err_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cpu_stall     = (state_reg != RUN);
  assign mem_raddr     = pc[ADDR_W+1:2];
  assign instruction   = (state_reg == RUN) ? mem_rdata : '0;
  assign pc_misaligned = (state_reg == RUN) && (pc[1:0] != 2'd0);
  // Fetch addresses alias above the memory size.
  assign unused_pc_hi  = ^pc[WORD_SIZE-1:ADDR_W+2];

  assign mem_we       = mem_we_reg;
  assign mem_waddr    = mem_waddr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign words_loaded = word_cnt_reg;
  assign load_err     = err_reg;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomised and directed bench for imem_load_arbiter against a queue-based load model.
module tb_imem_load_arbiter;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        reset, load_start, load_done, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] pc, instruction, mem_rdata, mem_wdata;
  logic        cpu_stall, pc_misaligned, mem_we, load_err;
  logic [7:0]  mem_raddr, mem_waddr;
  logic [8:0]  words_loaded;

  imem_load_arbiter dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_done(load_done),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pc(pc), .instruction(instruction), .cpu_stall(cpu_stall),
    .pc_misaligned(pc_misaligned), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .words_loaded(words_loaded), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int n_we = 0;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;
  logic chk_en = 1'b0;

  typedef struct { int due; logic [31:0] data; } pend_t;
  int          m_mode, m_words, ecount;
  logic        m_err, m_we;
  logic [7:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [7:0]  m_bytes[$];
  pend_t       m_pend[$];

  int r, we0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one rising edge using the inputs presented in the cycle before it.
  task automatic model_edge();
    pend_t p;
    ecount++;
    m_we = 1'b0;
    if (reset) begin
      m_mode = M_IDLE; m_words = 0; m_err = 1'b0;
      m_bytes.delete(); m_pend.delete();
      return;
    end
    if (load_start) begin
      m_mode = M_LOAD; m_words = 0; m_err = 1'b0;
      m_bytes.delete(); m_pend.delete();
    end else if (m_mode == M_LOAD) begin
      if (m_pend.size() > 0 && m_pend[0].due == ecount) begin
        p = m_pend.pop_front();
        if (m_words == DEPTH) m_err = 1'b1;
        else begin
          m_we = 1'b1; m_waddr = 8'(m_words); m_wdata = p.data; m_words++;
        end
      end
      if (load_done) begin
        m_mode = M_RUN;
        if (m_bytes.size() != 0) m_err = 1'b1;
        m_bytes.delete();
      end else if (byte_valid) begin
        m_bytes.push_back(byte_data);
        if (m_bytes.size() == 4) begin
          m_pend.push_back('{ecount + 1, {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]}});
          m_bytes.delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    load_start = 1'b0; load_done = 1'b0; byte_valid = 1'b0; reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1; tick(); load_start = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1; tick(); load_done = 1'b0;
  endtask

  task automatic at_sample();
    @(negedge clk); #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("words_loaded", 32'(words_loaded), 32'(m_words));
      chk("load_err", 32'(load_err), 32'(m_err));
      chk("cpu_stall", 32'(cpu_stall), 32'(m_mode != M_RUN));
      chk("byte_ready", 32'(byte_ready), 32'((m_mode == M_LOAD) && !load_done));
      chk("instruction", instruction, (m_mode == M_RUN) ? mem_rdata : 32'h0);
      chk("mem_raddr", 32'(mem_raddr), (pc >> 2) % DEPTH);
      chk("pc_misaligned", 32'(pc_misaligned), 32'((m_mode == M_RUN) && (pc % 4 != 0)));
      if (mem_we === 1'b1) begin
        n_we++; last_waddr = mem_waddr; last_wdata = mem_wdata;
      end
    end
  end

  initial begin
    m_mode = M_IDLE; m_words = 0; m_err = 1'b0; m_we = 1'b0; ecount = 0;
    m_waddr = '0; m_wdata = '0;
    clear_in(); reset = 1'b1; byte_data = 8'h00; pc = 32'h0; mem_rdata = 32'hDEADBEEF;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    at_sample();
    chk("reset_stall", 32'(cpu_stall), 32'd1);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_words", 32'(words_loaded), 32'd0);
    chk("reset_instr", instruction, 32'h0);
    $display("txn reset: stall=%0d words=%0d", cpu_stall, words_loaded);

    // Basic load of one word.
    we0 = n_we;
    pulse_start();
    send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    pulse_done();
    tick(); tick();
    at_sample();
    chk("basic_writes", 32'(n_we - we0), 32'd1);
    chk("basic_waddr", 32'(last_waddr), 32'd0);
    chk("basic_wdata", last_wdata, 32'h8C010004);
    chk("basic_words", 32'(words_loaded), 32'd1);
    chk("basic_stall", 32'(cpu_stall), 32'd0);
    $display("txn basic_load: wdata=%h words=%0d", last_wdata, words_loaded);

    // Fetch, misalignment and aliasing.
    pc = 32'h0000000C; mem_rdata = 32'h12345678;
    #1;
    chk("fetch_raddr", 32'(mem_raddr), 32'd3);
    chk("fetch_instr", instruction, 32'h12345678);
    pc = 32'h0000000E;
    #1;
    chk("fetch_misaligned", 32'(pc_misaligned), 32'd1);
    pc = 32'hABCD040C;
    #1;
    chk("fetch_alias", 32'(mem_raddr), 32'd3);
    $display("txn fetch: raddr=%0d instr=%h", mem_raddr, instruction);
    pc = 32'h0;
    tick();

    // Overflow: 257 words streamed back to back.
    we0 = n_we;
    pulse_start();
    for (int i = 0; i < 1028; i++) send_byte(8'($urandom));
    tick(); tick();
    at_sample();
    chk("ovf_writes", 32'(n_we - we0), 32'd256);
    chk("ovf_last_waddr", 32'(last_waddr), 32'd255);
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_words", 32'(words_loaded), 32'd256);
    pulse_done();
    tick();
    $display("txn overflow: writes=%0d err=%0d words=%0d", n_we - we0, load_err, words_loaded);

    // Partial word discarded at load_done.
    we0 = n_we;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    pulse_done();
    tick(); tick();
    at_sample();
    chk("partial_writes", 32'(n_we - we0), 32'd1);
    chk("partial_wdata", last_wdata, 32'h10111213);
    chk("partial_err", 32'(load_err), 32'd1);
    chk("partial_stall", 32'(cpu_stall), 32'd0);
    $display("txn partial: writes=%0d err=%0d", n_we - we0, load_err);

    // load_done beats a simultaneous byte that would otherwise complete a word.
    we0 = n_we;
    pulse_start();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    load_done = 1'b1; byte_valid = 1'b1; byte_data = 8'hA4;
    at_sample();
    chk("prio_ready", 32'(byte_ready), 32'd0);
    tick();
    clear_in();
    tick(); tick();
    at_sample();
    chk("prio_writes", 32'(n_we - we0), 32'd0);
    chk("prio_words", 32'(words_loaded), 32'd0);
    $display("txn priority: writes=%0d words=%0d", n_we - we0, words_loaded);

    // Reset in the cycle after the 4th byte drops the pending write.
    we0 = n_we;
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    at_sample();
    chk("rst_writes", 32'(n_we - we0), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_instr", instruction, 32'h0);
    $display("txn midload_reset: writes=%0d stall=%0d", n_we - we0, cpu_stall);

    // Randomised traffic.
    we0 = n_we;
    for (int c = 0; c < 4000; c++) begin
      clear_in();
      r = int'($urandom_range(0, 999));
      if (r < 2) reset = 1'b1;
      else begin
        case (m_mode)
          M_IDLE:  load_start = ($urandom_range(0, 3) == 0);
          M_LOAD:  load_start = ($urandom_range(0, 299) == 0);
          default: load_start = ($urandom_range(0, 19) == 0);
        endcase
        load_done = (m_mode == M_LOAD) ? ($urandom_range(0, 59) == 0)
                                       : ($urandom_range(0, 9) == 0);
        if (!load_start) byte_valid = ($urandom_range(0, 3) != 0);
      end
      byte_data = 8'($urandom);
      pc = $urandom;
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      mem_rdata = $urandom;
      tick();
    end
    clear_in();
    tick();
    $display("txn random: writes=%0d", n_we - we0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: instruction/data word width.
REQ-002 SHALL have parameter DEPTH, default 256: instruction memory words.
REQ-003 SHALL have parameter ADDR_W, default 8: word-index width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port load_start, input, 1: one-cycle pulse that begins a program load.
REQ-007 SHALL have port load_done, input, 1: one-cycle pulse that ends the load.
REQ-008 SHALL have port byte_valid, input, 1: loader byte present.
REQ-009 SHALL have port byte_data, input, 8: loader byte.
REQ-010 SHALL have port byte_ready, output, 1: byte accepted when byte_valid && byte_ready.
REQ-011 SHALL have port pc, input, WORD_SIZE: CPU byte address.
REQ-012 SHALL have port instruction, output, WORD_SIZE: fetched instruction to CPU.
REQ-013 SHALL have port cpu_stall, output, 1: CPU must hold its PC.
REQ-014 SHALL have port pc_misaligned, output, 1: pc[1:0] != 0 while running.
REQ-015 SHALL have port mem_raddr, output, ADDR_W: memory read word index.
REQ-016 SHALL have port mem_rdata, input, WORD_SIZE: memory read data (combinational read).
REQ-017 SHALL have ports mem_we (output, 1), mem_waddr (output, ADDR_W) and mem_wdata (output, WORD_SIZE): memory write port.
REQ-018 SHALL have port words_loaded, output, ADDR_W+1: count of words written in the current load.
REQ-019 SHALL have port load_err, output, 1: sticky error flag.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD and RUN.
REQ-021 SHALL make these FSM transitions:
- IDLE->LOAD on load_start.
- RUN->LOAD on load_start.
- LOAD->RUN on load_done.
- load_start in LOAD restarts the load: counters and load_err are cleared.
REQ-022 SHALL drive byte_ready = (state==LOAD) && !load_done, so load_done beats a simultaneous byte.
REQ-023 SHALL pack bytes big-endian: 1st accepted byte to [31:24], 4th to [7:0]; a 2-bit byte counter wraps 3->0.
REQ-024 SHALL register the memory write on the cycle the 4th byte is accepted:
- next cycle mem_we=1 for exactly one cycle.
- mem_waddr = current word counter.
- mem_wdata = the assembled word.
- the word counter and words_loaded then increment.
REQ-025 SHALL, when words_loaded already equals DEPTH and a further word completes, suppress the write, set load_err and leave the counter unchanged (no wrap-around).
REQ-026 SHALL, on load_done with byte counter != 0, discard the partial word and set load_err; the FSM still goes to RUN.
REQ-027 SHALL, on load_done, complete a write that is pending from the same or the previous cycle.
REQ-028 SHALL hold cpu_stall=1 in IDLE and LOAD, and 0 only in RUN.
REQ-029 SHALL drive mem_raddr = pc[ADDR_W+1:2] in all states.
REQ-030 SHALL drive instruction = mem_rdata in RUN, else 0 (NOP), combinationally with zero latency.
REQ-031 SHALL drive pc_misaligned = (state==RUN) && (pc[1:0]!=0), combinationally.
REQ-032 SHALL ignore pc bits above ADDR_W+1 (fetch aliasing).
REQ-033 SHALL ignore load_done in IDLE and RUN, and load_start and load_done together in the same cycle start a new load.

Reset
REQ-034 SHALL, on reset, set:
- state to IDLE.
- byte and word counters to 0.
- assembly register to 0.
- mem_we=0, mem_waddr=0, mem_wdata=0.
- words_loaded=0 and load_err=0.
REQ-035 SHALL drop any pending write when reset occurs mid-load; mem_we is 0 in the cycle after reset.

Structure
REQ-036 SHALL place WORD_SIZE, DEPTH and ADDR_W defaults and the state encoding in a shared package, imem_pkg.
REQ-037 SHALL use one sub-module, byte_word_packer (byte counter, assembly register, word-complete strobe); the FSM and write port stay at the top level.

Verification
REQ-038 SHALL verify basic load: load_start, bytes 8C 01 00 04, load_done -> one mem_we with waddr=0, wdata=0x8C010004; state RUN; cpu_stall=0; words_loaded=1.
REQ-039 SHALL verify fetch: RUN, pc=0x0000000C, mem_rdata=0x12345678 -> mem_raddr=3, instruction=0x12345678 in the same cycle; pc=0x0000000E -> pc_misaligned=1.
REQ-040 SHALL verify overflow: 257 words streamed -> 256 writes (waddr 0..255), load_err=1 after the 1028th byte, words_loaded=256.
REQ-041 SHALL verify partial word: 6 bytes then load_done -> one write, load_err=1, state RUN.
REQ-042 SHALL verify priority: load_done and byte_valid asserted together -> byte_ready=0, the byte is not counted.
REQ-043 SHALL verify mid-load reset: reset asserted in the cycle after the 4th byte -> no mem_we, state IDLE, instruction=0, cpu_stall=1.
